// File: rtl/motor_rr_scheduler.sv
// rtl/motor_rr_scheduler.sv - round-robin scheduler sharing one motor power feed among N_MOT motors
//
// Purpose : grants the power feed to at most one requesting motor at a time.
//           Every switch-over passes through an all-off dead-time. A time slice
//           applies only while another motor is waiting, and a minimum on-time
//           prevents short-cycling.
// Optional: define MOTOR_FAULT_MASK_EN to add per-motor fault masking and a sticky trip flag.
//
// Ports   : i_clk        clock
//           i_rst        synchronous reset, active-high
//           i_en         level, 0 flushes to IDLE (no dead-time)
//           i_test       level, 1 = tick at 10 Hz instead of 1 Hz
//           i_req        level requests (synchronised, debounced)
//           i_fault      level per-motor fault      (MOTOR_FAULT_MASK_EN only)
//           o_fault_trip sticky fault trip flag     (MOTOR_FAULT_MASK_EN only)
//           o_grant      one-hot or zero motor enables
//           o_cur_idx    index of the last granted motor
//           o_active     high in RUN
//           o_dead       high in DEAD
//           o_sec_cnt    tick count in the current state, saturating
module motor_rr_scheduler #(
    parameter int CLK_HZ     = 25_000_000,
    parameter int N_MOT      = 4,
    parameter int T_SLICE_S  = 30,
    parameter int T_MIN_ON_S = 5,
    parameter int T_DEAD_S   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_test,
    input  logic [N_MOT-1:0]         i_req,
`ifdef MOTOR_FAULT_MASK_EN
    input  logic [N_MOT-1:0]         i_fault,
    output logic                     o_fault_trip,
`endif
    output logic [N_MOT-1:0]         o_grant,
    output logic [$clog2(N_MOT)-1:0] o_cur_idx,
    output logic                     o_active,
    output logic                     o_dead,
    output logic [15:0]              o_sec_cnt
);

    localparam int IW = $clog2(N_MOT);
    localparam int PW = $clog2(CLK_HZ + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;

    localparam logic [15:0] L_SLICE  = 16'(T_SLICE_S);
    localparam logic [15:0] L_MIN_ON = 16'(T_MIN_ON_S);
    localparam logic [15:0] L_DEAD   = 16'(T_DEAD_S);
    localparam logic [N_MOT-1:0] L_ONE = {{(N_MOT-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [N_MOT-1:0] r_grant;
    logic [IW-1:0]    r_cur_idx;
    logic [15:0]      r_sec_cnt;
    logic [PW-1:0]    r_presc;

    logic [N_MOT-1:0] w_req_eff;
    logic             w_fault_cur;
    logic [N_MOT-1:0] w_cur_mask;
    logic             w_other;
    logic [PW-1:0]    w_div_m1;
    logic             w_tick;
    logic [IW-1:0]    w_pick;

`ifdef MOTOR_FAULT_MASK_EN
    logic r_fault_trip;

    assign w_req_eff   = i_req & ~i_fault;
    assign w_fault_cur = i_fault[r_cur_idx];
    assign o_fault_trip = r_fault_trip;

    // Sticky until reset; en=0 flushes before a trip can be taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fault_trip <= 1'b0;
        end else if (i_en && (r_state == S_RUN) && w_fault_cur) begin
            r_fault_trip <= 1'b1;
        end
    end
`else
    assign w_req_eff   = i_req;
    assign w_fault_cur = 1'b0;
`endif

    assign w_cur_mask = L_ONE << r_cur_idx;
    assign w_other    = |(w_req_eff & ~w_cur_mask);

    // Comparing with >= keeps the prescaler safe when i_test flips mid-count:
    // a count already past the shorter limit ticks at once instead of wrapping.
    assign w_div_m1 = i_test ? PW'(CLK_HZ / 10 - 1) : PW'(CLK_HZ - 1);
    assign w_tick   = (r_presc >= w_div_m1);

    // Search cur_idx+1, cur_idx+2, ... and cur_idx last. The loop runs from the
    // farthest offset down so the nearest requester is the final assignment.
    always_comb begin
        w_pick = r_cur_idx;
        for (int k = N_MOT; k >= 1; k--) begin
            if (w_req_eff[(int'(r_cur_idx) + k) % N_MOT]) begin
                w_pick = IW'((int'(r_cur_idx) + k) % N_MOT);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_cur_idx <= IW'(N_MOT - 1);
            r_sec_cnt <= '0;
            r_presc   <= '0;
        end else if (!i_en) begin
            // Flush: no dead-time, cur_idx kept so round-robin order survives.
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_sec_cnt <= '0;
            r_presc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sec_cnt <= '0;
                    r_presc   <= '0;
                    if (|w_req_eff) begin
                        r_state   <= S_RUN;
                        r_cur_idx <= w_pick;
                        r_grant   <= L_ONE << w_pick;
                    end
                end
                S_RUN: begin
                    // Fault, release after min-on, and preempt after slice all
                    // collapse into one transition to DEAD.
                    if (w_fault_cur ||
                        ((r_sec_cnt >= L_MIN_ON) && !i_req[r_cur_idx]) ||
                        ((r_sec_cnt >= L_SLICE) && w_other)) begin
                        r_state   <= S_DEAD;
                        r_grant   <= '0;
                        r_sec_cnt <= '0;
                        r_presc   <= '0;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_tick && (r_sec_cnt != 16'hFFFF)) begin
                            r_sec_cnt <= r_sec_cnt + 16'd1;
                        end
                    end
                end
                S_DEAD: begin
                    if (r_sec_cnt >= L_DEAD) begin
                        r_sec_cnt <= '0;
                        r_presc   <= '0;
                        if (|w_req_eff) begin
                            r_state   <= S_RUN;
                            r_cur_idx <= w_pick;
                            r_grant   <= L_ONE << w_pick;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_tick && (r_sec_cnt != 16'hFFFF)) begin
                            r_sec_cnt <= r_sec_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_grant   <= '0;
                    r_sec_cnt <= '0;
                    r_presc   <= '0;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_cur_idx = r_cur_idx;
    assign o_active  = (r_state == S_RUN);
    assign o_dead    = (r_state == S_DEAD);
    assign o_sec_cnt = r_sec_cnt;

`ifndef SYNTHESIS
    a_grant_onehot0: assert property (@(posedge i_clk) $onehot0(o_grant));
`endif

endmodule

// File: tb/tb_motor_rr_scheduler.sv
// tb/tb_motor_rr_scheduler.sv - directed table-driven bench for motor_rr_scheduler
module tb_motor_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       test;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] cur_idx;
    logic       active;
    logic       dead;
    logic [15:0] sec_cnt;
`ifdef MOTOR_FAULT_MASK_EN
    logic [3:0] fault;
    logic       fault_trip;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_rr_scheduler #(
        .CLK_HZ(100), .N_MOT(4), .T_SLICE_S(3), .T_MIN_ON_S(1), .T_DEAD_S(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_en(en),
        .i_test(test),
        .i_req(req),
`ifdef MOTOR_FAULT_MASK_EN
        .i_fault(fault),
        .o_fault_trip(fault_trip),
`endif
        .o_grant(grant),
        .o_cur_idx(cur_idx),
        .o_active(active),
        .o_dead(dead),
        .o_sec_cnt(sec_cnt)
    );

    typedef struct {
        logic       en;
        logic       test;
        logic [3:0] req;
        int         n;
        logic [3:0] grant;
        logic [1:0] cur;
        logic       act;
        logic       dead;
        logic [15:0] sec;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_vec++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".grant"},  int'(grant),   int'(v.grant));
        chk({tag, ".cur"},    int'(cur_idx), int'(v.cur));
        chk({tag, ".active"}, int'(active),  int'(v.act));
        chk({tag, ".dead"},   int'(dead),    int'(v.dead));
        chk({tag, ".sec"},    int'(sec_cnt), int'(v.sec));
    endtask

    initial begin
        int cnt;
        // en test req n | grant cur act dead sec
        // Alternation with req=0101: slice 3 ticks, dead 1 tick.
        vt.push_back('{1, 0, 4'b0101,   1, 4'b0001, 2'd0, 1, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0101,  99, 4'b0001, 2'd0, 1, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0101,   1, 4'b0001, 2'd0, 1, 0, 16'd1});
        vt.push_back('{1, 0, 4'b0101, 200, 4'b0001, 2'd0, 1, 0, 16'd3});
        vt.push_back('{1, 0, 4'b0101,   1, 4'b0000, 2'd0, 0, 1, 16'd0});
        vt.push_back('{1, 0, 4'b0101, 100, 4'b0000, 2'd0, 0, 1, 16'd1});
        vt.push_back('{1, 0, 4'b0101,   1, 4'b0100, 2'd2, 1, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0101, 301, 4'b0000, 2'd2, 0, 1, 16'd0});
        vt.push_back('{1, 0, 4'b0101, 101, 4'b0001, 2'd0, 1, 0, 16'd0});
        // Mid-RUN en=0 flush, then resume at next round-robin index.
        vt.push_back('{1, 0, 4'b0101, 150, 4'b0001, 2'd0, 1, 0, 16'd1});
        vt.push_back('{0, 0, 4'b0101,   1, 4'b0000, 2'd0, 0, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0101,   1, 4'b0100, 2'd2, 1, 0, 16'd0});
        // Single requester held 20 ticks: no slice, no DEAD.
        vt.push_back('{0, 0, 4'b0010,   1, 4'b0000, 2'd2, 0, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0010,   1, 4'b0010, 2'd1, 1, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0010,2000, 4'b0010, 2'd1, 1, 0, 16'd20});
        // One-cycle request pulse: held for min-on, DEAD 1 tick, then IDLE.
        vt.push_back('{0, 0, 4'b0001,   1, 4'b0000, 2'd1, 0, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0001,   1, 4'b0001, 2'd0, 1, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0000,  99, 4'b0001, 2'd0, 1, 0, 16'd0});
        vt.push_back('{1, 0, 4'b0000,   1, 4'b0001, 2'd0, 1, 0, 16'd1});
        vt.push_back('{1, 0, 4'b0000,   1, 4'b0000, 2'd0, 0, 1, 16'd0});
        vt.push_back('{1, 0, 4'b0000, 100, 4'b0000, 2'd0, 0, 1, 16'd1});
        vt.push_back('{1, 0, 4'b0000,   1, 4'b0000, 2'd0, 0, 0, 16'd0});
        // Test mode: tick every 10 cycles; switching 1->0 and 0->1 mid-count.
        vt.push_back('{1, 1, 4'b0100,   1, 4'b0100, 2'd2, 1, 0, 16'd0});
        vt.push_back('{1, 1, 4'b0100,   9, 4'b0100, 2'd2, 1, 0, 16'd0});
        vt.push_back('{1, 1, 4'b0100,   1, 4'b0100, 2'd2, 1, 0, 16'd1});
        vt.push_back('{1, 1, 4'b0100,  10, 4'b0100, 2'd2, 1, 0, 16'd2});
        vt.push_back('{1, 1, 4'b0100,   5, 4'b0100, 2'd2, 1, 0, 16'd2});
        vt.push_back('{1, 0, 4'b0100,  94, 4'b0100, 2'd2, 1, 0, 16'd2});
        vt.push_back('{1, 0, 4'b0100,   1, 4'b0100, 2'd2, 1, 0, 16'd3});
        vt.push_back('{1, 0, 4'b0100,  50, 4'b0100, 2'd2, 1, 0, 16'd3});
        vt.push_back('{1, 1, 4'b0100,   1, 4'b0100, 2'd2, 1, 0, 16'd4});
        // Release and preempt in the same cycle: one DEAD, then next requester.
        vt.push_back('{1, 1, 4'b0001,   1, 4'b0000, 2'd2, 0, 1, 16'd0});
        vt.push_back('{1, 1, 4'b0001,  10, 4'b0000, 2'd2, 0, 1, 16'd1});
        vt.push_back('{1, 1, 4'b0001,   1, 4'b0001, 2'd0, 1, 0, 16'd0});

        rst = 1'b1; en = 1'b0; test = 1'b0; req = 4'b0000;
`ifdef MOTOR_FAULT_MASK_EN
        fault = 4'b0000;
`endif
        step(3);
        chk_all("reset", '{0, 0, 4'b0000, 0, 4'b0000, 2'd3, 0, 0, 16'd0});
`ifdef MOTOR_FAULT_MASK_EN
        chk("reset.fault_trip", int'(fault_trip), 0);
`endif
        rst = 1'b0;
        step(1);
        chk("idle_no_en.grant", int'(grant), 0);

        for (int i = 0; i < vt.size(); i++) begin
            en = vt[i].en; test = vt[i].test; req = vt[i].req;
            step(vt[i].n);
            chk_all($sformatf("v%0d", i), vt[i]);
        end

        // Preempt timing in normal mode: 301 cycles to DEAD, 101 more to next grant.
        test = 1'b0; req = 4'b1001;
        cnt = 0;
        while (!dead && cnt < 1000) begin
            step(1);
            cnt++;
        end
        chk("preempt.dead_seen", int'(dead), 1);
        chk("preempt.cycles", cnt, 301);
        cnt = 0;
        while (grant == 4'b0000 && cnt < 1000) begin
            step(1);
            cnt++;
        end
        chk("preempt.dead_cycles", cnt, 101);
        chk("preempt.grant", int'(grant), 4'b1000);
        chk("preempt.cur", int'(cur_idx), 3);

`ifdef MOTOR_FAULT_MASK_EN
        en = 1'b0; step(1);
        en = 1'b1; req = 4'b0011; step(1);
        chk("fault.grant0", int'(grant), 4'b0001);
        chk("fault.trip_pre", int'(fault_trip), 0);
        fault = 4'b0001; step(1);
        chk("fault.dead", int'(dead), 1);
        chk("fault.trip", int'(fault_trip), 1);
        step(101);
        chk("fault.grant1", int'(grant), 4'b0010);
        chk("fault.cur1", int'(cur_idx), 1);
        step(500);
        chk("fault.no_regrant", int'(grant), 4'b0010);
        chk("fault.trip_sticky", int'(fault_trip), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
